// File: rtl/fx_writeback_queue.sv
// fx_writeback_queue
// Writeback stage behind the fixed-point unit. Each FX result can carry a GPR
// write, a special-register (CR/XER) write, or both. The stage keeps results
// in a small in-order FIFO and drains them onto the single register-file write
// port, one write per cycle, under a valid/ready handshake.
//
// Ports
//   clock_i                 clock, all state updates on posedge
//   reset_i                 synchronous active-high reset
//   functionalUnitCode_i    producing unit code; only FXUnitCode is captured
//   reg1WritebackEnable_i   GPR write requested
//   reg2WritebackEnable_i   special write requested
//   reg1WritebackAddress_i  GPR target
//   reg2WritebackAddress_i  special-register field target
//   reg1WritebackVal_i      GPR data (bit 0 = MSB in architectural numbering)
//   reg2WritebackVal_i      special data
//   writeReady_i            register file accepts the presented write
//   writeValid_o            a write is presented
//   writeTarget_o           0 = GPR, 1 = special
//   writeAddress_o          presented write address
//   writeVal_o              presented write data
//   stall_o                 dispatch must not issue to FX
//   empty_o                 nothing buffered
//   count_o                 current occupancy in entries
//   overflow_o              sticky: a valid result arrived while full
module fx_writeback_queue #(
    parameter int unsigned regWidth       = 5,
    parameter int unsigned FXUnitCode     = 0,
    parameter int unsigned queueDepthLog2 = 2,
    parameter int unsigned stallMargin    = 2
) (
    input  logic                      clock_i,
    input  logic                      reset_i,
    input  logic [2:0]                functionalUnitCode_i,
    input  logic                      reg1WritebackEnable_i,
    input  logic                      reg2WritebackEnable_i,
    input  logic [regWidth-1:0]       reg1WritebackAddress_i,
    input  logic [regWidth-1:0]       reg2WritebackAddress_i,
    input  logic [63:0]               reg1WritebackVal_i,
    input  logic [63:0]               reg2WritebackVal_i,
    input  logic                      writeReady_i,
    output logic                      writeValid_o,
    output logic                      writeTarget_o,
    output logic [regWidth-1:0]       writeAddress_o,
    output logic [63:0]               writeVal_o,
    output logic                      stall_o,
    output logic                      empty_o,
    output logic [queueDepthLog2:0]   count_o,
    output logic                      overflow_o
);

    localparam int unsigned DEPTH = 1 << queueDepthLog2;
    localparam int unsigned PTR_W = queueDepthLog2;
    localparam int unsigned CNT_W = queueDepthLog2 + 1;
    localparam int unsigned STALL_LEVEL = DEPTH - stallMargin;

    // Entry storage: pending flags are reset, payload is not.
    logic                pend1_q [DEPTH];
    logic                pend2_q [DEPTH];
    logic [regWidth-1:0] addr1_q [DEPTH];
    logic [regWidth-1:0] addr2_q [DEPTH];
    logic [63:0]         val1_q  [DEPTH];
    logic [63:0]         val2_q  [DEPTH];

    logic [PTR_W-1:0]    rd_ptr_q;
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [CNT_W-1:0]    count_q;
    logic                overflow_q;

    logic                in_valid;
    logic                full;
    logic                push;
    logic                drop;
    logic                head_p1;
    logic                head_p2;
    logic                head_valid;
    logic                xfer;
    logic                pop;

    // Input qualification and FIFO control.
    always_comb begin
        in_valid   = (reg1WritebackEnable_i | reg2WritebackEnable_i)
                   & (functionalUnitCode_i == 3'(FXUnitCode));
        full       = (count_q == CNT_W'(DEPTH));
        // Full blocks a push even when the head pops this cycle.
        push       = in_valid & ~full;
        drop       = in_valid & full;
        head_p1    = pend1_q[rd_ptr_q];
        head_p2    = pend2_q[rd_ptr_q];
        head_valid = (count_q != '0) & (head_p1 | head_p2);
        xfer       = head_valid & writeReady_i;
        // GPR write goes first; the entry retires once its last pending write transfers.
        pop        = xfer & (head_p1 ? ~head_p2 : 1'b1);
    end

    // Control state: pointers, occupancy, pending flags, sticky overflow.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                pend1_q[i] <= 1'b0;
                pend2_q[i] <= 1'b0;
            end
        end else begin
            // A push never targets the head slot while it is transferring:
            // that would need count == 0 (no transfer) or count == DEPTH (no push).
            if (push) begin
                pend1_q[wr_ptr_q] <= reg1WritebackEnable_i;
                pend2_q[wr_ptr_q] <= reg2WritebackEnable_i;
                wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
            end
            if (xfer) begin
                if (head_p1) begin
                    pend1_q[rd_ptr_q] <= 1'b0;
                end else begin
                    pend2_q[rd_ptr_q] <= 1'b0;
                end
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Payload capture.
    always_ff @(posedge clock_i) begin
        if (push) begin
            addr1_q[wr_ptr_q] <= reg1WritebackAddress_i;
            addr2_q[wr_ptr_q] <= reg2WritebackAddress_i;
            val1_q[wr_ptr_q]  <= reg1WritebackVal_i;
            val2_q[wr_ptr_q]  <= reg2WritebackVal_i;
        end
    end

    // Output mux from registered head state only; idle outputs are driven to zero.
    always_comb begin
        writeValid_o   = head_valid;
        writeTarget_o  = head_valid & ~head_p1;
        writeAddress_o = '0;
        writeVal_o     = '0;
        if (head_valid) begin
            writeAddress_o = head_p1 ? addr1_q[rd_ptr_q] : addr2_q[rd_ptr_q];
            writeVal_o     = head_p1 ? val1_q[rd_ptr_q]  : val2_q[rd_ptr_q];
        end
        stall_o    = (count_q >= CNT_W'(STALL_LEVEL));
        empty_o    = (count_q == '0);
        count_o    = count_q;
        overflow_o = overflow_q;
    end

endmodule

// File: tb/tb_fx_writeback_queue.sv
// Scoreboard bench for fx_writeback_queue: stimulus pushes expected writes,
// a negedge monitor pops and compares each transfer on the write port.
module tb_fx_writeback_queue;

    typedef struct packed {
        logic        tgt;
        logic [4:0]  addr;
        logic [63:0] val;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  fu;
    logic        en1;
    logic        en2;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [63:0] v1;
    logic [63:0] v2;
    logic        ready;
    logic        wvalid;
    logic        wtarget;
    logic [4:0]  waddr;
    logic [63:0] wval;
    logic        stall;
    logic        empty;
    logic [2:0]  count;
    logic        overflow;

    wr_t sb[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    fx_writeback_queue dut (
        .clock_i                (clk),
        .reset_i                (rst),
        .functionalUnitCode_i   (fu),
        .reg1WritebackEnable_i  (en1),
        .reg2WritebackEnable_i  (en2),
        .reg1WritebackAddress_i (a1),
        .reg2WritebackAddress_i (a2),
        .reg1WritebackVal_i     (v1),
        .reg2WritebackVal_i     (v2),
        .writeReady_i           (ready),
        .writeValid_o           (wvalid),
        .writeTarget_o          (wtarget),
        .writeAddress_o         (waddr),
        .writeVal_o             (wval),
        .stall_o                (stall),
        .empty_o                (empty),
        .count_o                (count),
        .overflow_o             (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Present one FX result for one edge; queue its expected writes if it should be accepted.
    task automatic issue(input logic e1, input logic e2, input logic [4:0] ad1, input logic [63:0] d1,
                         input logic [4:0] ad2, input logic [63:0] d2, input logic [2:0] code,
                         input bit accept);
        wr_t w;
        fu = code; en1 = e1; en2 = e2; a1 = ad1; a2 = ad2; v1 = d1; v2 = d2;
        if (accept) begin
            if (e1) begin w.tgt = 1'b0; w.addr = ad1; w.val = d1; sb.push_back(w); end
            if (e2) begin w.tgt = 1'b1; w.addr = ad2; w.val = d2; sb.push_back(w); end
        end
        @(posedge clk); #1;
        en1 = 1'b0; en2 = 1'b0; fu = 3'd0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every transfer must match the scoreboard head; held writes must stay stable.
    wr_t held;
    bit  holding = 1'b0;
    always @(negedge clk) begin
        wr_t exp;
        if (wvalid && ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", {wtarget, waddr}, 6'h3f);
            end else begin
                exp = sb.pop_front();
                chk("write_target", 64'(wtarget), 64'(exp.tgt));
                chk("write_addr", 64'(waddr), 64'(exp.addr));
                chk("write_val", wval, exp.val);
            end
        end
        if (wvalid && !ready) begin
            if (holding) chk("held_write_stable", {wtarget, waddr, wval}, {held.tgt, held.addr, held.val});
            held.tgt = wtarget; held.addr = waddr; held.val = wval;
            holding = 1'b1;
        end else begin
            holding = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; ready = 1'b0; fu = 3'd0; en1 = 1'b0; en2 = 1'b0;
        a1 = '0; a2 = '0; v1 = '0; v2 = '0;
        step(2);
        rst = 1'b0;
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_empty", 64'(empty), 64'd1);
        chk("reset_stall", 64'(stall), 64'd0);
        chk("reset_overflow", 64'(overflow), 64'd0);
        chk("reset_valid", 64'(wvalid), 64'd0);
        chk("reset_addr_val", {wtarget, waddr, wval[57:0]}, 64'd0);

        // Single GPR write, one-cycle latency.
        ready = 1'b1;
        issue(1, 0, 5'd3, 64'h10, 5'd0, 64'h0, 3'd0, 1);
        chk("single_valid", 64'(wvalid), 64'd1);
        chk("single_count", 64'(count), 64'd1);
        step(1);
        chk("single_empty", 64'(empty), 64'd1);
        chk("single_idle", 64'(wvalid), 64'd0);

        // Dual write: GPR then special, two cycles at the head.
        issue(1, 1, 5'd5, 64'hFF, 5'd0, 64'h8000_0000_0000_0000, 3'd0, 1);
        chk("dual_first_target", 64'(wtarget), 64'd0);
        step(1);
        chk("dual_second_target", 64'(wtarget), 64'd1);
        chk("dual_still_queued", 64'(count), 64'd1);
        step(1);
        chk("dual_empty", 64'(empty), 64'd1);

        // Back-pressure, stall threshold, overflow.
        ready = 1'b0;
        issue(1, 0, 5'd10, 64'hA0, 5'd0, 64'h0, 3'd0, 1);
        chk("bp_stall_at_1", 64'(stall), 64'd0);
        issue(1, 0, 5'd11, 64'hA1, 5'd0, 64'h0, 3'd0, 1);
        chk("bp_stall_at_2", 64'(stall), 64'd1);
        issue(1, 0, 5'd12, 64'hA2, 5'd0, 64'h0, 3'd0, 1);
        issue(1, 0, 5'd13, 64'hA3, 5'd0, 64'h0, 3'd0, 1);
        chk("bp_count_full", 64'(count), 64'd4);
        chk("bp_overflow_clear", 64'(overflow), 64'd0);
        issue(1, 1, 5'd14, 64'hA4, 5'd1, 64'hB4, 3'd0, 0);
        chk("bp_overflow_set", 64'(overflow), 64'd1);
        chk("bp_count_after_drop", 64'(count), 64'd4);
        step(3);
        chk("bp_overflow_sticky", 64'(overflow), 64'd1);
        ready = 1'b1;
        step(4);
        chk("bp_drained", 64'(empty), 64'd1);
        chk("bp_overflow_after_drain", 64'(overflow), 64'd1);

        // Foreign unit code is ignored.
        issue(1, 1, 5'd7, 64'h77, 5'd2, 64'h22, 3'd1, 0);
        chk("foreign_count", 64'(count), 64'd0);
        chk("foreign_valid", 64'(wvalid), 64'd0);

        // Streaming with wrap: occupancy holds at 1.
        for (int i = 0; i < 8; i++) begin
            issue(1, 0, 5'(16 + i), 64'h1000 + 64'(i), 5'd0, 64'h0, 3'd0, 1);
            chk("stream_count", 64'(count), 64'd1);
        end
        step(1);
        chk("stream_empty", 64'(empty), 64'd1);

        // Reset discards queued entries.
        ready = 1'b0;
        issue(1, 0, 5'd20, 64'hC0, 5'd0, 64'h0, 3'd0, 1);
        issue(0, 1, 5'd0, 64'h0, 5'd21, 64'hC1, 3'd0, 1);
        issue(1, 1, 5'd22, 64'hC2, 5'd23, 64'hC3, 3'd0, 1);
        chk("pre_reset_count", 64'(count), 64'd3);
        rst = 1'b1;
        sb.delete();
        step(1);
        rst = 1'b0;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_valid", 64'(wvalid), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);

        ready = 1'b1;
        step(3);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fx_writeback_queue.md
# fx_writeback_queue

Writeback stage directly downstream of the fixed-point unit. It captures each registered FX result (GPR write plus optional CR/XER write), buffers it in a small in-order FIFO, and drains it one write per cycle onto the single register-file write port using a valid/ready handshake. Its stall output lets dispatch throttle FX issue before the buffer overflows.

## Interface
- regWidth, 5, register address width
- FXUnitCode, 0, functional unit code accepted from the FX unit
- queueDepthLog2, 2, log2 of FIFO depth (depth 4)
- stallMargin, 2, stall_o asserts when occupancy >= depth - stallMargin

- clock_i  in  1  clock, all state updates on posedge
- reset_i  in  1  synchronous, active-high reset
- functionalUnitCode_i  in  3  producing unit code from FX unit
- reg1WritebackEnable_i  in  1  GPR write requested
- reg2WritebackEnable_i  in  1  special (CR/XER) write requested
- reg1WritebackAddress_i  in  regWidth  GPR target
- reg2WritebackAddress_i  in  regWidth  special-register field target
- reg1WritebackVal_i  in  64  GPR data, bit 0 = MSB
- reg2WritebackVal_i  in  64  special data
- writeReady_i  in  1  register file accepts the presented write this cycle
- writeValid_o  out  1  a write is presented
- writeTarget_o  out  1  0 = GPR, 1 = special
- writeAddress_o  out  regWidth  write address
- writeVal_o  out  64  write data
- stall_o  out  1  dispatch must not issue to FX
- empty_o  out  1  FIFO empty and no write pending
- count_o  out  queueDepthLog2+1  current occupancy (entries)
- overflow_o  out  1  sticky: a valid result arrived while full

## Operation
- Input valid = (reg1WritebackEnable_i | reg2WritebackEnable_i) & (functionalUnitCode_i == FXUnitCode).
- Entry fields: pend1, pend2, addr1, addr2, val1, val2. Push copies pend1/pend2 from the enables.
- Push accepted iff valid & count < depth. Valid while count == depth (even if popping that cycle): result dropped, overflow_o set, stays set until reset.
- Head drain order: GPR write first, then special write. writeTarget_o = 0 while head pend1 = 1, else 1.
- writeValid_o = !empty & (head pend1 | head pend2). Outputs are muxed from registered head state only; no combinational path from any *_i except writeReady_i affects nothing combinationally either.
- Transfer = writeValid_o & writeReady_i. On transfer: clear the bit currently presented; if no pending bit remains, pop (advance read pointer).
- Entry with only pend2 presents the special write immediately; entry with only pend1 pops after one transfer.
- Pointers wrap modulo depth; count tracks push minus pop, simultaneous push and pop leaves count unchanged.
- stall_o = count >= depth - stallMargin (combinational from count).
- empty_o = (count == 0).
- Presented address/value must stay stable while writeValid_o = 1 and writeReady_i = 0.

## Timing
- Reset (sync, dominates all other inputs): count 0, read/write pointers 0, all pend bits 0, writeValid_o 0, writeTarget_o 0, writeAddress_o 0, writeVal_o 0, stall_o 0, empty_o 1, overflow_o 0. Entries in flight at reset are discarded; no write presented the cycle after.
- Latency: result valid at edge N is pushed at edge N; writeValid_o high throughout cycle N+1 (earliest transfer at edge N+1).
- Throughput: one write per cycle with writeReady_i held high; two-write entry occupies head for 2 cycles.
- stall_o reflects post-edge count, visible the cycle after the push causing it; margin 2 covers the FX unit's registered output in flight.
- Back-pressure: writeReady_i low holds head indefinitely; pushes continue until full.

## Test plan
- Reset then single push (r1 en, addr 3, val 0x0000_0000_0000_0010, r2 en 0) -> writeValid_o next cycle, target 0, addr 3, val 0x10; pop after one transfer; empty_o returns 1.
- Push with both enables (addr1 5 val 0xFF, addr2 0 val 0x8000_0000_0000_0000), writeReady_i high -> cycle 1 GPR write addr 5, cycle 2 special write addr 0, then empty.
- writeReady_i low, push 4 single-write results -> count_o 4, stall_o high from count 2; 5th valid -> dropped, overflow_o 1 and sticky; release ready -> 4 writes drain in order.
- Push with functionalUnitCode_i = 1 and enables high -> ignored, count_o stays 0, no write.
- Steady push + ready high for 8 cycles with wrap -> count_o stays 1, writes emerge in order with 1-cycle latency, pointers wrap correctly.
- Assert reset_i with 3 entries queued and ready low -> next cycle count_o 0, writeValid_o 0, overflow_o 0, empty_o 1.
